ft245_frame_tx: RTL and testbench
=================================

// Module: ft245_frame_tx
// PURPOSE
//  Transmit-side counterpart of the acquisition controller: consumes the FFT
//  output stream a frame at a time and writes it byte-wise to the FT2232H
//  FT245 synchronous FIFO. Each frame is a header, a frame counter, the
//  samples (MSB byte first) and an XOR checksum. Runs in the FT 60 MHz domain.
//  Pulses done when the last byte has been accepted by the FT2232H.
// PARAMETERS
//  DATA_WIDTH   25     FFT sample width (bits), two's complement
//  N_SAMPLES    1024   samples per frame (>=1)
//  HEADER_BYTE  8'hA5  first byte of every frame
//  (derived) NB = ceil(DATA_WIDTH/8) bytes per sample
// PORTS
//  clk        in   1           FT 60 MHz clock
//  rst        in   1           synchronous, active-high reset
//  en         in   1           start request; sampled only in IDLE
//  in_valid   in   1           upstream sample valid
//  in_data    in   DATA_WIDTH  upstream sample
//  in_ready   out  1           sample taken on edge where in_valid & in_ready
//  ft_txe_n   in   1           FT2232H TX FIFO has space when low
//  ft_wr_n    out  1           write strobe, active low, registered
//  ft_data    out  8           byte to FT2232H, registered
//  done       out  1           one-cycle pulse at end of frame
//  busy       out  1           high in every state except IDLE
// BEHAVIOUR
//  - Reset: state IDLE, ft_wr_n=1, ft_data=8'h00, in_ready=0, done=0, busy=0,
//    frame counter=0, checksum=0, sample count=0. Reset mid-frame aborts
//    immediately; no further byte strobed; partial frame is not resumed.
//  - Byte accept: a byte transfers on a rising edge where ft_wr_n==0 and
//    ft_txe_n==0. While ft_txe_n is high, ft_wr_n stays low and ft_data holds;
//    no byte is skipped or repeated.
//  - States:
//    IDLE   : ft_wr_n=1. en=1 -> HEADER, loading ft_data=HEADER_BYTE,
//             ft_wr_n=0, checksum=0.
//    HEADER : on accept -> COUNT, ft_data=frame counter.
//    COUNT  : on accept -> LOAD, ft_wr_n=1.
//    LOAD   : in_ready=1 (combinational from state), ft_wr_n=1. On
//             in_valid: sign-extend sample to NB*8 bits, capture it,
//             -> DATA with ft_data=MS byte, ft_wr_n=0. No in_valid: stay.
//    DATA   : on each accept shift out the next byte. After byte NB is
//             accepted: sample count==N_SAMPLES-1 -> FOOTER with
//             ft_data=checksum; otherwise -> LOAD, count+1, ft_wr_n=1.
//    FOOTER : on accept -> DONE, ft_wr_n=1.
//    DONE   : done=1 for exactly this cycle; frame counter+1 (8-bit, wraps
//             255->0); sample count=0; -> IDLE.
//  - Checksum: XOR of every accepted byte from HEADER through the last DATA
//    byte; updated on each accept edge; the footer is excluded.
//  - in_ready is low outside LOAD. en is ignored outside IDLE. Dropping en
//    mid-frame does not abort. en held high gives back-to-back frames, with
//    one IDLE cycle between DONE and the next HEADER.
//  - Unstalled throughput: 1 LOAD + NB DATA cycles per sample. Frame length
//    is 3 + N_SAMPLES*(NB+1) cycles from HEADER to FOOTER, plus 1 DONE cycle.
//  - Unreachable state encodings -> IDLE with outputs at their reset values.
// TESTING (DATA_WIDTH=12, N_SAMPLES=4, NB=2 unless stated)
//  1 en pulse, ft_txe_n=0, in_valid=1, samples 123,FFF,800,07F -> bytes
//    A5 00 01 23 FF FF F8 00 00 7F 00; done high 16 cycles after the en edge.
//  2 Second frame, same samples -> counter byte 01, checksum byte 01; third
//    frame counter byte 02.
//  3 ft_txe_n high 5 cycles while byte F8 is pending -> ft_wr_n stays low,
//    ft_data=F8 held; still exactly 11 bytes accepted, same sequence.
//  4 in_valid low 7 cycles in LOAD before sample 3 -> in_ready high the whole
//    wait, ft_wr_n=1, frame content unchanged, done 7 cycles later than case 1.
//  5 rst pulsed after 4 bytes -> next cycle ft_wr_n=1, busy=0, done never
//    fires; next frame restarts with A5 00.
//  6 en held high for 257 frames -> counter byte goes FF then 00, done
//    pulses once per frame, one IDLE cycle between frames.

Source files
------------

// File: rtl/ft245_frame_tx_if.sv
// ft245_frame_tx_if: sample stream and FT245 FIFO signals of the frame transmitter.
interface ft245_frame_tx_if #(
    parameter int DATA_WIDTH = 25
);
    logic                  en;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  ft_txe_n;
    logic                  ft_wr_n;
    logic [7:0]            ft_data;
    logic                  done;
    logic                  busy;
    modport master (
        output en, in_valid, in_data, ft_txe_n,
        input  in_ready, ft_wr_n, ft_data, done, busy
    );
    modport slave (
        input  en, in_valid, in_data, ft_txe_n,
        output in_ready, ft_wr_n, ft_data, done, busy
    );
endinterface

// File: rtl/ft245_frame_tx.sv
// ft245_frame_tx: frames the FFT sample stream (header, counter, samples MSB first,
// XOR checksum) and writes it byte-wise to the FT245 synchronous FIFO.
module ft245_frame_tx #(
    parameter int         DATA_WIDTH  = 25,
    parameter int         N_SAMPLES   = 1024,
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input logic            clk,
    input logic            rst,
    ft245_frame_tx_if.slave io
);
    localparam int NB = (DATA_WIDTH + 7) / 8;
    localparam int SW = NB * 8;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    localparam int CW = N_SAMPLES > 1 ? $clog2(N_SAMPLES) : 1;
    typedef enum logic [2:0] {IDLE, HEADER, COUNT, LOAD, DATA, FOOTER, DONE} state_t;
    state_t        state;
    logic [SW-1:0] ext;
    logic [SW-1:0] shreg;
    logic [BW-1:0] bcnt;
    logic [CW-1:0] scnt;
    logic [7:0]    fcnt;
    logic [7:0]    csum;
    logic          acc;
    assign ext         = SW'($signed(io.in_data));
    assign acc         = !io.ft_wr_n && !io.ft_txe_n;
    assign io.in_ready = state == LOAD;
    always_ff @(posedge clk) begin
        if (rst || state == state_t'(3'd7)) begin
            state      <= IDLE;
            io.ft_wr_n <= 1'b1;
            io.ft_data <= 8'h00;
            io.done    <= 1'b0;
            io.busy    <= 1'b0;
            fcnt       <= 8'h00;
            csum       <= 8'h00;
            scnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
        end else begin
            case (state)
                IDLE: if (io.en) begin
                    state      <= HEADER;
                    io.ft_data <= HEADER_BYTE;
                    io.ft_wr_n <= 1'b0;
                    io.busy    <= 1'b1;
                    csum       <= 8'h00;
                end
                HEADER: if (acc) begin
                    state      <= COUNT;
                    io.ft_data <= fcnt;
                    csum       <= csum ^ io.ft_data;
                end
                COUNT: if (acc) begin
                    state      <= LOAD;
                    io.ft_wr_n <= 1'b1;
                    csum       <= csum ^ io.ft_data;
                end
                LOAD: if (io.in_valid) begin
                    state      <= DATA;
                    io.ft_data <= ext[SW-1 -: 8];
                    io.ft_wr_n <= 1'b0;
                    shreg      <= ext << 8;
                    bcnt       <= BW'(NB - 1);
                end
                // bcnt counts the bytes of the current sample still queued behind ft_data
                DATA: if (acc) begin
                    csum <= csum ^ io.ft_data;
                    if (bcnt != '0) begin
                        io.ft_data <= shreg[SW-1 -: 8];
                        shreg      <= shreg << 8;
                        bcnt       <= bcnt - BW'(1);
                    end else if (scnt == CW'(N_SAMPLES - 1)) begin
                        state      <= FOOTER;
                        io.ft_data <= csum ^ io.ft_data;
                    end else begin
                        state      <= LOAD;
                        io.ft_wr_n <= 1'b1;
                        scnt       <= scnt + CW'(1);
                    end
                end
                FOOTER: if (acc) begin
                    state      <= DONE;
                    io.ft_wr_n <= 1'b1;
                    io.done    <= 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    io.done <= 1'b0;
                    io.busy <= 1'b0;
                    fcnt    <= fcnt + 8'd1;
                    scnt    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ft245_frame_tx.sv
// tb_ft245_frame_tx: directed and randomized frames checked against a byte-list frame model.
module tb_ft245_frame_tx;
    localparam int DW = 12;
    localparam int NS = 4;
    localparam int NB = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ft245_frame_tx_if #(.DATA_WIDTH(DW)) dif ();
    ft245_frame_tx #(.DATA_WIDTH(DW), .N_SAMPLES(NS), .HEADER_BYTE(8'hA5)) dut (
        .clk(clk),
        .rst(rst),
        .io (dif)
    );
    int nassert = 0;
    int nfail = 0;
    int smp[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int idx, ndone, nbusy;
    bit hold_en, rnd_txe, rnd_valid, stall_armed;
    logic [7:0] stall_byte, fcm, p_data;
    int stall_len, txe_hold, gap_idx, gap_left;
    bit p_stall, p_wait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        nassert++;
        assert (obs === want) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // frame = header, counter, sign-extended samples MSB byte first, XOR of all preceding bytes
    task automatic build_exp(input logic [7:0] fc);
        logic [7:0] x;
        int v;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(fc);
        foreach (smp[i]) begin
            v = smp[i] >= 2048 ? smp[i] - 4096 : smp[i];
            for (int b = NB - 1; b >= 0; b--) exp_q.push_back(8'(v >>> (8 * b)));
        end
        x = 8'h00;
        foreach (exp_q[i]) x ^= exp_q[i];
        exp_q.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (p_stall) begin
            chk("stall_wr_n", dif.ft_wr_n, 0);
            chk("stall_hold", dif.ft_data, p_data);
        end
        if (p_wait) begin
            chk("wait_ready", dif.in_ready, 1);
            chk("wait_wr_n", dif.ft_wr_n, 1);
        end
        if (dif.busy) nbusy++;
        if (dif.done) ndone++;
        if (stall_armed && !dif.ft_wr_n && dif.ft_data == stall_byte) begin
            txe_hold = stall_len;
            stall_armed = 0;
        end
        dif.ft_txe_n = txe_hold > 0 || (rnd_txe && $urandom_range(3) == 0);
        if (txe_hold > 0) txe_hold--;
        if (idx == gap_idx && gap_left > 0 && dif.in_ready) begin
            dif.in_valid = 1'b0;
            gap_left--;
        end else dif.in_valid = !(rnd_valid && $urandom_range(3) == 0);
        dif.in_data = idx < smp.size() ? DW'(smp[idx]) : '0;
        if (!dif.ft_wr_n && !dif.ft_txe_n) got.push_back(dif.ft_data);
        if (dif.in_valid && dif.in_ready) idx++;
        p_stall = !dif.ft_wr_n && dif.ft_txe_n;
        p_data = dif.ft_data;
        p_wait = dif.in_ready && !dif.in_valid;
    endtask

    task automatic frame(input int exp_busy);
        build_exp(fcm);
        got.delete();
        idx = 0;
        ndone = 0;
        nbusy = 0;
        dif.en = 1'b1;
        dif.in_data = DW'(smp[0]);
        cyc();
        chk("start_busy", dif.busy, 1);
        if (!hold_en) dif.en = 1'b0;
        for (int i = 0; i < 2000 && ndone == 0; i++) cyc();
        chk("done_count", ndone, 1);
        if (exp_busy > 0) chk("busy_len", nbusy, exp_busy);
        chk("byte_count", got.size(), exp_q.size());
        foreach (exp_q[i]) chk($sformatf("byte%0d", i), i < got.size() ? 32'(got[i]) : 32'hFFFF_FFFF, exp_q[i]);
        cyc();
        chk("idle_busy", dif.busy, 0);
        chk("idle_done", dif.done, 0);
        chk("idle_wr_n", dif.ft_wr_n, 1);
        fcm++;
    endtask

    task automatic rand_smp();
        smp.delete();
        repeat (NS) smp.push_back(int'($urandom_range(4095)));
    endtask

    initial begin
        dif.en = 1'b0;
        dif.in_valid = 1'b0;
        dif.in_data = '0;
        dif.ft_txe_n = 1'b0;
        {hold_en, rnd_txe, rnd_valid, stall_armed, p_stall, p_wait} = '0;
        txe_hold = 0;
        gap_idx = -1;
        gap_left = 0;
        fcm = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_n", dif.ft_wr_n, 1);
        chk("rst_data", dif.ft_data, 8'h00);
        chk("rst_ready", dif.in_ready, 0);
        chk("rst_done", dif.done, 0);
        chk("rst_busy", dif.busy, 0);
        rst = 1'b0;
        cyc();
        smp = '{'h123, 'hFFF, 'h800, 'h07F};
        frame(16);
        frame(16);
        frame(16);
        stall_byte = 8'hF8;
        stall_len = 5;
        stall_armed = 1;
        frame(21);
        chk("stall_used", stall_armed, 0);
        gap_idx = 2;
        gap_left = 7;
        frame(23);
        chk("gap_used", gap_left, 0);
        gap_idx = -1;
        // abort a frame after its fourth byte
        got.delete();
        idx = 0;
        ndone = 0;
        dif.en = 1'b1;
        cyc();
        dif.en = 1'b0;
        for (int i = 0; i < 100 && got.size() < 4; i++) cyc();
        chk("pre_rst_bytes", got.size(), 4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dif.ft_txe_n = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        dif.ft_txe_n = 1'b0;
        p_stall = 0;
        p_wait = 0;
        fcm = 8'h00;
        chk("abort_wr_n", dif.ft_wr_n, 1);
        chk("abort_busy", dif.busy, 0);
        chk("abort_ready", dif.in_ready, 0);
        repeat (6) cyc();
        chk("abort_no_done", ndone, 0);
        chk("abort_no_bytes", got.size(), 4);
        frame(16);
        hold_en = 1;
        for (int f = 0; f < 257; f++) begin
            rand_smp();
            frame(16);
        end
        hold_en = 0;
        dif.en = 1'b0;
        rnd_txe = 1;
        rnd_valid = 1;
        for (int f = 0; f < 6; f++) begin
            rand_smp();
            frame(0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
